// File: rtl/store_merge_rmw_pkg.sv
// Shared encodings for the store narrowing path: access sizes, controller
// states and the alignment rule that decides whether a store is rejected.
package mips_store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Size 2'b11 has no meaning and is rejected like a misaligned access.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops narrow store data into the addressed
// byte/half lane of an existing word; a word-size store passes data through.
module store_lane_merge
    import mips_store_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    logic [1:0] lane;

    // For halves, lane[1] picks the upper 16 bits in either byte order.
    always_comb begin
        lane   = (BIG_ENDIAN != 0) ? (2'd3 - off) : off;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]   = data[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
    end

endmodule

// File: rtl/store_merge_rmw.sv
// Store controller for a word-only data memory: word stores write directly,
// byte/half stores do read, merge, write back; bad requests end in ERR.
module store_merge_rmw
    import mips_store_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and inputs are ignored otherwise.
    state_e      state_q;
    logic [31:2] waddr_q;
    logic [31:0] data_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] merged;

    store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .off      (off_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            waddr_q <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        waddr_q <= req_addr[31:2];
                        data_q  <= req_data;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_data;
                        if (req_bad(req_size, req_addr[1:0])) state_q <= ERR;
                        else if (req_size == SZ_WORD)         state_q <= WRITE;
                        else                                  state_q <= READ;
                    end
                end
                READ:  state_q <= MERGE;
                // mem_rdata carries the word fetched during READ.
                MERGE: begin
                    wdata_q <= merged;
                    state_q <= WRITE;
                end
                WRITE:   state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_rd_en = (state_q == READ);
    assign mem_wr_en = (state_q == WRITE);
    assign mem_wdata = wdata_q;
    assign done      = (state_q == WRITE) || (state_q == ERR);
    assign err       = (state_q == ERR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: little- and big-endian instances share stimulus,
// each backed by its own word memory model and expected-write queue.
module tb_store_merge_rmw;
  import mips_store_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;

  logic        le_ready, le_rd_en, le_wr_en, le_done, le_err;
  logic [31:0] le_addr, le_wdata, le_rdata;
  logic [2:0]  le_state;
  logic        be_ready, be_rd_en, be_wr_en, be_done, be_err;
  logic [31:0] be_addr, be_wdata, be_rdata;
  logic [2:0]  be_state;

  logic [31:0] mem_le [16];
  logic [31:0] mem_be [16];
  logic        pre_en;
  logic [31:0] pre_addr, pre_data;

  logic [63:0] exp_le_q[$];
  logic [63:0] exp_be_q[$];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int acc_cnt  = 0;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] preset;
    logic [31:0] exp_le;
    logic [31:0] exp_be;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  store_merge_rmw #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(le_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(le_addr), .mem_rd_en(le_rd_en), .mem_rdata(le_rdata),
    .mem_wr_en(le_wr_en), .mem_wdata(le_wdata), .done(le_done), .err(le_err),
    .dbg_state(le_state)
  );

  store_merge_rmw #(.BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(be_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(be_addr), .mem_rd_en(be_rd_en), .mem_rdata(be_rdata),
    .mem_wr_en(be_wr_en), .mem_wdata(be_wdata), .done(be_done), .err(be_err),
    .dbg_state(be_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // word memory models: read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (pre_en) begin
      mem_le[pre_addr[5:2]] <= pre_data;
      mem_be[pre_addr[5:2]] <= pre_data;
    end
    if (le_rd_en) le_rdata <= mem_le[le_addr[5:2]];
    if (le_wr_en) mem_le[le_addr[5:2]] <= le_wdata;
    if (be_rd_en) be_rdata <= mem_be[be_addr[5:2]];
    if (be_wr_en) mem_be[be_addr[5:2]] <= be_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [63:0] e;
    if (le_wr_en) begin
      if (exp_le_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL le_unexpected_write: got %08h at %08h expected none", le_wdata, le_addr);
      end else begin
        e = exp_le_q.pop_front();
        chk("le_wr_addr", le_addr, e[63:32]);
        chk("le_wr_data", le_wdata, e[31:0]);
      end
    end
    if (be_wr_en) begin
      if (exp_be_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL be_unexpected_write: got %08h at %08h expected none", be_wdata, be_addr);
      end else begin
        e = exp_be_q.pop_front();
        chk("be_wr_addr", be_addr, e[63:32]);
        chk("be_wr_data", be_wdata, e[31:0]);
      end
    end
    if (le_done) done_cnt++;
    if (le_err)  err_cnt++;
    if (req_valid && le_ready) acc_cnt++;
  end

  // driver tasks
  task automatic preset(input logic [31:0] addr, input logic [31:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    logic narrow;
    logic [31:0] aligned;
    aligned = {v.addr[31:2], 2'b00};
    narrow  = !v.exp_err && (v.size != SZ_WORD);
    lat     = narrow ? 3 : 1;
    preset(v.addr, v.preset);
    if (!v.exp_err) begin
      exp_le_q.push_back({aligned, v.exp_le});
      exp_be_q.push_back({aligned, v.exp_be});
    end
    chk($sformatf("v%0d_ready_before", idx), {31'b0, le_ready & be_ready}, 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom; req_data = $urandom; req_size = 2'($urandom_range(0, 3));
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("v%0d_c%0d_rd_en", idx, k), {30'b0, le_rd_en, be_rd_en},
          {30'b0, narrow && k == 1, narrow && k == 1});
      chk($sformatf("v%0d_c%0d_wr_en", idx, k), {30'b0, le_wr_en, be_wr_en},
          {30'b0, !v.exp_err && k == lat, !v.exp_err && k == lat});
      chk($sformatf("v%0d_c%0d_done_err", idx, k), {28'b0, le_done, le_err, be_done, be_err},
          {28'b0, k == lat, v.exp_err && k == lat, k == lat, v.exp_err && k == lat});
      if (narrow && k == 1)
        chk($sformatf("v%0d_rd_addr", idx), le_addr, aligned);
      if (k < lat) @(negedge clk);
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", idx), {31'b0, le_ready & be_ready}, 32'd1);
    chk($sformatf("v%0d_state_idle", idx), {29'b0, le_state}, 32'd0);
    chk($sformatf("v%0d_addr_hold", idx), le_addr, aligned);
  endtask

  initial begin
    int n;
    logic [1:0]  b2b_size [3];
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int dones0, errs0, acc0;

    vecs[0]  = '{SZ_BYTE, 32'h12, 32'h0000_0055, 32'hAABBCCDD, 32'hAA55CCDD, 32'hAABB55DD, 1'b0};
    vecs[1]  = '{SZ_HALF, 32'h12, 32'hFFFF_1234, 32'hAABBCCDD, 32'h1234CCDD, 32'hAABB1234, 1'b0};
    vecs[2]  = '{SZ_WORD, 32'h14, 32'hDEAD_BEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{SZ_HALF, 32'h11, 32'h0000_1111, 32'hAABBCCDD, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{SZ_WORD, 32'h16, 32'h2222_2222, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[5]  = '{2'b11,   32'h10, 32'h3333_3333, 32'hAABBCCDD, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{SZ_BYTE, 32'h10, 32'h1234_5677, 32'hAABBCCDD, 32'hAABBCC77, 32'h77BBCCDD, 1'b0};
    vecs[7]  = '{SZ_BYTE, 32'h13, 32'h0000_00EE, 32'hAABBCCDD, 32'hEEBBCCDD, 32'hAABBCCEE, 1'b0};
    vecs[8]  = '{SZ_HALF, 32'h10, 32'h0000_BEEF, 32'hAABBCCDD, 32'hAABBBEEF, 32'hBEEFCCDD, 1'b0};
    vecs[9]  = '{SZ_BYTE, 32'h11, 32'h0000_0001, 32'hAABBCCDD, 32'hAABB01DD, 32'hAA01CCDD, 1'b0};
    vecs[10] = '{SZ_WORD, 32'h20, 32'h0123_4567, 32'h0,        32'h01234567, 32'h01234567, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'b0, le_state}, 32'd0);
    chk("rst_strobes", {27'b0, le_rd_en, le_wr_en, le_done, le_err, le_ready}, 32'd0);
    chk("rst_mem_addr", le_addr, 32'd0);
    chk("rst_mem_wdata", le_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, le_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // reset during MERGE: the byte store must be abandoned without a write
    preset(32'h10, 32'hAABBCCDD);
    dones0 = done_cnt;
    req_valid = 1'b1; req_addr = 32'h10; req_data = 32'h11; req_size = SZ_BYTE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read", {31'b0, le_rd_en}, 32'd1);
    @(negedge clk);
    chk("abort_in_merge", {29'b0, le_state}, 32'(MERGE));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_state", {29'b0, le_state, be_state}, 32'd0);
    chk("abort_done", {30'b0, le_done, le_wr_en}, 32'd0);
    chk("abort_ready", {31'b0, le_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dones0), 32'd0);
    chk("abort_mem_le", mem_le[4], 32'hAABBCCDD);
    chk("abort_mem_be", mem_be[4], 32'hAABBCCDD);

    // req_valid held high across three queued stores
    preset(32'h10, 32'hAABBCCDD);
    b2b_size[0] = SZ_BYTE; b2b_addr[0] = 32'h13; b2b_data[0] = 32'h0000_0099;
    b2b_size[1] = SZ_WORD; b2b_addr[1] = 32'h18; b2b_data[1] = 32'hCAFE_F00D;
    b2b_size[2] = SZ_HALF; b2b_addr[2] = 32'h10; b2b_data[2] = 32'h0000_7777;
    exp_le_q.push_back({32'h10, 32'h99BBCCDD});
    exp_le_q.push_back({32'h18, 32'hCAFEF00D});
    exp_le_q.push_back({32'h10, 32'h99BB7777});
    exp_be_q.push_back({32'h10, 32'hAABBCC99});
    exp_be_q.push_back({32'h18, 32'hCAFEF00D});
    exp_be_q.push_back({32'h10, 32'h7777CC99});
    dones0 = done_cnt; errs0 = err_cnt; acc0 = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_size = b2b_size[i]; req_addr = b2b_addr[i]; req_data = b2b_data[i];
      n = 0;
      while (!le_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++; failures++;
        $display("FAIL b2b_ready_timeout: got ready=0 expected ready=1 within 20 cycles");
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
    chk("b2b_dones", 32'(done_cnt - dones0), 32'd3);
    chk("b2b_errs", 32'(err_cnt - errs0), 32'd0);
    chk("b2b_mem_le", mem_le[4], 32'h99BB7777);
    chk("b2b_mem_be", mem_be[4], 32'h7777CC99);

    chk("le_queue_drained", 32'(exp_le_q.size()), 32'd0);
    chk("be_queue_drained", 32'(exp_be_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
